// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone pattern master.
// Holds:
//   - the FSM state type;
//   - the cycle-type (CTI) codes;
//   - the data-pattern key and the pattern generator used for writes and read compares.
package wb_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitInit,
    StWrBurst,
    StWrGap,
    StRdBurst,
    StRdGap,
    StDone
  } state_e;

  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [2:0]  CTI_EOB     = 3'b111;
  localparam logic [31:0] PATTERN_KEY = 32'hA5A5_5A5A;

  // Data word tied to its own address, so a misrouted beat reads back wrong.
  function automatic logic [31:0] gen_pattern(input logic [25:0] addr);
    return {6'b0, addr} ^ PATTERN_KEY;
  endfunction

endpackage

// File: rtl/wb_pattern_chk.sv
// Read-data checker for the Wishbone pattern master.
// It compares each acknowledged read beat with the expected pattern for its address.
// It also keeps a saturating mismatch count and the address of the first mismatch.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            start of a new run; clears count and captured address
//   chk_en_i           a read beat is acknowledged this cycle
//   addr_i, rd_data_i  beat address and returned data
//   err_cnt_o          mismatch count, saturates at 16'hFFFF
//   first_err_addr_o   address of the first mismatch since clear_i
module wb_pattern_chk
  import wb_master_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        chk_en_i,
  input  logic [25:0] addr_i,
  input  logic [31:0] rd_data_i,
  output logic [15:0] err_cnt_o,
  output logic [25:0] first_err_addr_o
);

  logic [15:0] err_cnt_q, err_cnt_d;
  logic [25:0] first_q, first_d;
  logic        mismatch;

  always_comb begin
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    mismatch  = chk_en_i && (rd_data_i != gen_pattern(addr_i));
    if (clear_i) begin
      err_cnt_d = '0;
      first_d   = '0;
    end else if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'h0000) first_d = addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/wb_pattern_master.sv
// Wishbone memory test master.
// After start_i and SDRAM init it runs two phases:
//   - writes NUM_BURSTS incrementing bursts of BURST_LEN address-derived words;
//   - reads the same bursts back and compares them.
// Each burst is followed by one idle cycle.
// Optional feature (macro WB_MASTER_TIMEOUT_EN): an 8-bit stall watchdog.
// The watchdog aborts the run to DONE with timeout_o set after 255 unacknowledged strobe cycles.
// Without the macro, the master waits forever for ack and timeout_o is 0.
// Ports:
//   wb_clk_i, wb_rst_i (async, active-low)
//   start_i, sdr_init_done                                  control inputs
//   wb_cyc_o/stb_o/we_o/addr_o/dat_o/sel_o/cti_o            Wishbone request
//   wb_ack_i, wb_dat_i                                      Wishbone response
//   busy_o, done_o, err_cnt_o, first_err_addr_o, timeout_o  status
module wb_pattern_master
  import wb_master_pkg::*;
#(
  parameter logic [25:0] BASE_ADDR  = 26'h0,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned NUM_BURSTS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        sdr_init_done,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [25:0] wb_addr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] err_cnt_o,
  output logic [25:0] first_err_addr_o,
  output logic        timeout_o
);

  localparam logic [3:0] LastBeat  = 4'(BURST_LEN - 1);
  localparam logic [7:0] LastBurst = 8'(NUM_BURSTS - 1);

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [7:0]  burst_q, burst_d;
  logic        in_burst, last_beat, start_run, wdog_expired;
  logic [23:0] beat_idx;
  logic [25:0] beat_addr;

  always_comb begin
    in_burst  = (state_q == StWrBurst) || (state_q == StRdBurst);
    last_beat = (beat_q == LastBeat);
    start_run = start_i && ((state_q == StIdle) || (state_q == StDone));
    beat_idx  = 24'(32'(burst_q) * BURST_LEN + 32'(beat_q));
    beat_addr = BASE_ADDR + {beat_idx, 2'b00};
  end

`ifdef WB_MASTER_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       timeout_q, timeout_d;

  // Counts consecutive stalled strobe cycles; wdog_q==254 marks the 255th.
  always_comb begin
    wdog_d       = '0;
    wdog_expired = in_burst && !wb_ack_i && (wdog_q == 8'd254);
    if (in_burst && !wb_ack_i) wdog_d = wdog_q + 8'd1;
    timeout_d = timeout_q;
    if (start_run) timeout_d = 1'b0;
    else if (wdog_expired) timeout_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wdog_expired = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_run) begin
          state_d = StWaitInit;
          beat_d  = '0;
          burst_d = '0;
        end
      end
      StWaitInit: begin
        if (sdr_init_done) state_d = StWrBurst;
      end
      StWrBurst, StRdBurst: begin
        if (wdog_expired) begin
          state_d = StDone;
        end else if (wb_ack_i) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = (state_q == StWrBurst) ? StWrGap : StRdGap;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      StWrGap: begin
        if (burst_q == LastBurst) begin
          burst_d = '0;
          state_d = StRdBurst;
        end else begin
          burst_d = burst_q + 8'd1;
          state_d = StWrBurst;
        end
      end
      StRdGap: begin
        if (burst_q == LastBurst) begin
          burst_d = '0;
          state_d = StDone;
        end else begin
          burst_d = burst_q + 8'd1;
          state_d = StRdBurst;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
      beat_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
    end
  end

  // Request outputs are decoded from state only, so reset forces them to 0 at once.
  always_comb begin
    wb_cyc_o  = in_burst;
    wb_stb_o  = in_burst;
    wb_we_o   = (state_q == StWrBurst);
    wb_sel_o  = in_burst ? 4'hF : 4'h0;
    wb_addr_o = in_burst ? beat_addr : '0;
    wb_dat_o  = (state_q == StWrBurst) ? gen_pattern(beat_addr) : '0;
    wb_cti_o  = in_burst ? (last_beat ? CTI_EOB : CTI_INCR) : 3'b000;
    busy_o    = (state_q != StIdle) && (state_q != StDone);
    done_o    = (state_q == StDone);
  end

  wb_pattern_chk u_chk (
    .clk_i            (wb_clk_i),
    .rst_ni           (wb_rst_i),
    .clear_i          (start_run),
    .chk_en_i         ((state_q == StRdBurst) && wb_ack_i),
    .addr_i           (beat_addr),
    .rd_data_i        (wb_dat_i),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o)
  );

endmodule

// File: tb/tb_wb_pattern_master.sv
// Directed bench for wb_pattern_master.
// It drives a default-parameter instance against a memory-backed slave.
// It also drives a BURST_LEN=1 / NUM_BURSTS=2 instance against a pattern-returning slave.
module tb_wb_pattern_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, init_done, ack_block, corrupt_en;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_cnt  = 0;
  always @(posedge clk) cyc_cnt++;

  // Default instance
  logic        start1, cyc1, stb1, we1, ack1, busy1, done1, tmo1;
  logic [25:0] addr1, ferr1;
  logic [31:0] wdat1, rdat1;
  logic [3:0]  sel1;
  logic [2:0]  cti1;
  logic [15:0] err1;
  logic [31:0] mem [0:127];

  // BURST_LEN=1 instance
  logic        start2, cyc2, stb2, we2, ack2, busy2, done2, tmo2;
  logic [25:0] addr2, ferr2;
  logic [31:0] wdat2, rdat2;
  logic [3:0]  sel2;
  logic [2:0]  cti2;
  logic [15:0] err2;

  function automatic logic [31:0] exp_pat(input logic [25:0] a);
    return {6'b0, a} ^ 32'hA5A5_5A5A;
  endfunction

  assign ack1  = cyc1 & stb1 & ~ack_block;
  assign rdat1 = mem[addr1[8:2]] ^
                 ((corrupt_en && (addr1 == 26'h040 || addr1 == 26'h080)) ? 32'h1 : 32'h0);
  always @(posedge clk) if (cyc1 && stb1 && ack1 && we1) mem[addr1[8:2]] <= wdat1;

  assign ack2  = cyc2 & stb2;
  assign rdat2 = exp_pat(addr2);

  wb_pattern_master u_dut (
    .wb_clk_i (clk), .wb_rst_i (rst_n), .start_i (start1), .sdr_init_done (init_done),
    .wb_cyc_o (cyc1), .wb_stb_o (stb1), .wb_we_o (we1), .wb_addr_o (addr1),
    .wb_dat_o (wdat1), .wb_sel_o (sel1), .wb_cti_o (cti1), .wb_ack_i (ack1),
    .wb_dat_i (rdat1), .busy_o (busy1), .done_o (done1), .err_cnt_o (err1),
    .first_err_addr_o (ferr1), .timeout_o (tmo1)
  );

  wb_pattern_master #(.BURST_LEN(1), .NUM_BURSTS(2)) u_dut_bl1 (
    .wb_clk_i (clk), .wb_rst_i (rst_n), .start_i (start2), .sdr_init_done (init_done),
    .wb_cyc_o (cyc2), .wb_stb_o (stb2), .wb_we_o (we2), .wb_addr_o (addr2),
    .wb_dat_o (wdat2), .wb_sel_o (sel2), .wb_cti_o (cti2), .wb_ack_i (ack2),
    .wb_dat_i (rdat2), .busy_o (busy2), .done_o (done2), .err_cnt_o (err2),
    .first_err_addr_o (ferr2), .timeout_o (tmo2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start pulse placed mid-cycle so monitors see it cleanly at the next negedge.
  task automatic pulse_start(input int which);
    @(posedge clk); #1;
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int max_cyc);
    int n = 0;
    while (((which == 1) ? !done1 : !done2) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (which == 1) check_eq("done1_wait", done1, 1);
    else check_eq("done2_wait", done2, 1);
  endtask

  // Monitor for the default instance
  int          wr_acks = 0, rd_acks = 0, bus_cycles = 0;
  logic [25:0] max_addr = '0;
  always @(negedge clk) begin
    int idx;
    if (cyc1) bus_cycles++;
    if (start1 && !busy1) begin
      wr_acks  = 0;
      rd_acks  = 0;
      max_addr = '0;
    end else if (cyc1 && stb1 && ack1) begin
      idx = we1 ? wr_acks : rd_acks;
      check_eq(we1 ? "wr_addr" : "rd_addr", addr1, 26'(idx * 4));
      check_eq("sel", sel1, 4'hF);
      check_eq("cti", cti1, ((idx % 8) == 7) ? 3'b111 : 3'b010);
      if (we1) begin
        check_eq("wr_data", wdat1, exp_pat(26'(idx * 4)));
        wr_acks++;
      end else begin
        rd_acks++;
      end
      if (addr1 > max_addr) max_addr = addr1;
    end
  end

  // Monitor for the BURST_LEN=1 instance
  int acks2 = 0, last_ack2 = 0;
  always @(negedge clk) begin
    if (start2 && !busy2) begin
      acks2 = 0;
    end else if (cyc2 && stb2 && ack2) begin
      check_eq("bl1_cti", cti2, 3'b111);
      check_eq("bl1_addr", addr2, 26'((acks2 % 2) * 4));
      if (acks2 > 0) check_eq("bl1_gap", cyc_cnt - last_ack2, 2);
      last_ack2 = cyc_cnt;
      acks2++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int viol, snap, n;
    rst_n = 1'b0; init_done = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ack_block = 1'b0; corrupt_en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_bus", {cyc1, stb1, we1, sel1, cti1}, 0);
    check_eq("rst_status", {busy1, done1, tmo1}, 0);
    check_eq("rst_err", err1, 0);
    check_eq("rst_ferr", ferr1, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("idle_no_bus", bus_cycles, 0);

    // Single-beat bursts
    init_done = 1'b1;
    pulse_start(2);
    wait_done(2, 200);
    check_eq("bl1_acks", acks2, 4);
    check_eq("bl1_err", err2, 0);
    check_eq("bl1_busy", busy2, 0);

    // Init held off for 500 cycles, then a full clean run
    init_done = 1'b0;
    pulse_start(1);
    viol = 0;
    repeat (500) begin
      @(negedge clk);
      if (!busy1 || cyc1) viol++;
    end
    check_eq("wait_init_hold", viol, 0);
    init_done = 1'b1;
    @(negedge clk);
    check_eq("first_write_after_init", cyc1, 1);
    wait_done(1, 2000);
    check_eq("wr_acks", wr_acks, 128);
    check_eq("rd_acks", rd_acks, 128);
    check_eq("clean_err", err1, 0);
    check_eq("max_addr", max_addr, 26'h1FC);
    check_eq("done_not_busy", busy1, 0);

    // Corrupted reads at 0x040 and 0x080
    corrupt_en = 1'b1;
    pulse_start(1);
    @(negedge clk);
    check_eq("start_clears_done", done1, 0);
    wait_done(1, 2000);
    check_eq("corrupt_err", err1, 2);
    check_eq("corrupt_first", ferr1, 26'h040);
    corrupt_en = 1'b0;

    // Reset during write beat 3
    pulse_start(1);
    @(negedge clk);
    check_eq("start_clears_err", err1, 0);
    check_eq("start_clears_ferr", ferr1, 0);
    n = 0;
    while (!(cyc1 && addr1 == 26'h00C) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_beat3", addr1, 26'h00C);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_bus", {cyc1, stb1, we1, sel1, cti1}, 0);
    check_eq("midrst_addr_dat", {addr1, 6'b0} | wdat1, 0);
    check_eq("midrst_status", {busy1, done1, tmo1}, 0);
    check_eq("midrst_err", {err1, ferr1[15:0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    snap = bus_cycles;
    repeat (20) @(negedge clk);
    check_eq("post_rst_no_bus", bus_cycles - snap, 0);
    check_eq("post_rst_idle", busy1, 0);

`ifdef WB_MASTER_TIMEOUT_EN
    // First beat never acknowledged
    ack_block = 1'b1;
    pulse_start(1);
    n = 0;
    snap = 0;
    while (!done1 && snap < 400) begin
      @(negedge clk);
      if (stb1) n++;
      snap++;
    end
    check_eq("tmo_stall_cycles", n, 255);
    check_eq("tmo_cyc", cyc1, 0);
    check_eq("tmo_flag", tmo1, 1);
    check_eq("tmo_done", done1, 1);
    ack_block = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
